// File: rtl/axis_add_tail.sv
// axis_add_tail: forwards data beats, then closes each frame with one generated tail beat (tlast=1).
// Optional build macro AXIS_ADD_TAIL_CNT_EN: the tail's low CNT_WIDTH bits carry the accepted-beat count.
module axis_add_tail #(
  parameter int unsigned           DATA_WIDTH  = 64,
  parameter int unsigned           CNT_WIDTH   = 16,
  parameter logic [DATA_WIDTH-1:0] TAIL_MARKER = DATA_WIDTH'(64'hFFFF_0000_0000_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_WIDTH-1:0]  frame_len,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_e;

  state_e                state_q;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tlast_q;
  logic                  tvalid_q;

  logic                  ld_ok;
  logic                  in_hs;
  logic [DATA_WIDTH-1:0] tail_data_d;

  // NOTE: every output of this block is assigned on every path, so no latch is inferred.
  always_comb begin
    ld_ok         = !tvalid_q || m_axis_tready;
    s_axis_tready = (state_q == DATA) && ld_ok;
    in_hs         = s_axis_tvalid && s_axis_tready;
`ifdef AXIS_ADD_TAIL_CNT_EN
    tail_data_d   = {TAIL_MARKER[DATA_WIDTH-1:CNT_WIDTH], cnt_q};
`else
    tail_data_d   = TAIL_MARKER;
`endif
  end

  // NOTE: non-blocking assignments; the ld_ok clear of tvalid_q is overridden by a later load in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      if (ld_ok) tvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          len_q   <= frame_len;
          cnt_q   <= '0;
          state_q <= (frame_len == '0) ? TAIL : DATA;
        end
        DATA: begin
          if (in_hs) begin
            tdata_q  <= s_axis_tdata;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b1;
            cnt_q    <= cnt_q + CNT_WIDTH'(1);
            // Length reached and early tlast on the same beat still give a single tail.
            if ((cnt_q == len_q - CNT_WIDTH'(1)) || s_axis_tlast) state_q <= TAIL;
          end
        end
        TAIL: begin
          if (ld_ok) begin
            tdata_q  <= tail_data_d;
            tlast_q  <= 1'b1;
            tvalid_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;

endmodule

// File: doc/axis_add_tail.md
# axis_add_tail

Framing stage placed directly upstream of the tail-dropping stage in the PAICORE datapath. It passes a stream of `DATA_WIDTH`-bit data beats downstream, then closes each frame with one generated tail beat carrying `tlast=1`. The downstream stage consumes and drops that tail beat. Frame length is a runtime input, and an input `tlast` may terminate a frame early.

## Interface
- `DATA_WIDTH`, 64, beat width.
- `CNT_WIDTH`, 16, width of the frame-length and beat counters; must be < `DATA_WIDTH`.
- `TAIL_MARKER`, 64'hFFFF_0000_0000_0000, constant tail pattern (`DATA_WIDTH` bits).

Ports:
- `clk`, in, 1, clock. One clock domain; all ports are sampled on its rising edge.
- `rst`, in, 1, reset. Synchronous and active-high.
- `frame_len`, in, `CNT_WIDTH`, data beats per frame; sampled in IDLE.
- `s_axis_tready`, out, 1, input ready.
- `s_axis_tdata`, in, `DATA_WIDTH`, input data.
- `s_axis_tlast`, in, 1, early end-of-frame on a data beat.
- `s_axis_tvalid`, in, 1, input valid.
- `m_axis_tready`, in, 1, output ready.
- `m_axis_tdata`, out, `DATA_WIDTH`, registered output data.
- `m_axis_tlast`, out, 1, registered; 1 only on tail beats.
- `m_axis_tvalid`, out, 1, registered output valid.

## Operation
- Output register: one stage, with `ld_ok = !m_axis_tvalid || m_axis_tready`.
  - On `ld_ok` with nothing to load, `m_axis_tvalid` goes to 0.
  - While `m_axis_tvalid && !m_axis_tready`, tdata, tlast and tvalid are held stable.
- FSM states are IDLE, DATA and TAIL; reset state is IDLE.
- IDLE, lasting exactly 1 cycle:
  - `len_q <= frame_len` and `cnt <= 0`.
  - Next state is TAIL if `frame_len == 0`, otherwise DATA.
  - `s_axis_tready = 0`.
- DATA:
  - `s_axis_tready = ld_ok`.
  - On handshake, the output register loads `{s_axis_tdata, tlast=0}` and `cnt <= cnt + 1`.
  - If `cnt == len_q-1` or `s_axis_tlast == 1`, go to TAIL.
  - Input tlast is never forwarded.
- TAIL:
  - `s_axis_tready = 0`.
  - On `ld_ok`, the output register loads the tail beat with tlast=1, then go to IDLE.
  - Tail data without the macro is `TAIL_MARKER`.
- Counters: `cnt` holds the number of data beats actually accepted in the frame, including the beat that triggers the transition. It never wraps, because `len_q ≤ 2^CNT_WIDTH-1`.
- `frame_len` changes outside IDLE have no effect until the next frame.
- Simultaneous early `s_axis_tlast` on beat `len_q-1`: a single transition to TAIL; no double tail.
- `frame_len == 0`: a tail-only frame is emitted. This repeats every 2 cycles while the value stays 0.

## Timing
- Reset values: `m_axis_tvalid=0`, `m_axis_tdata=0`, `m_axis_tlast=0`, `s_axis_tready=0`, state=IDLE, `cnt=0`, `len_q=0`.
- Latency: an accepted input beat appears on `m_axis_*` in the next cycle.
- `s_axis_tready` combinationally depends on `m_axis_tready` in DATA.
- Throughput:
  - 1 beat/cycle inside DATA when `m_axis_tready` is held high.
  - Per-frame overhead is 2 cycles: 1 tail cycle plus 1 IDLE bubble. A frame of N beats therefore takes N+2 cycles.
- Tail beat: valid the cycle after the TAIL load, so with ready held high it follows the last data beat back-to-back.
- `rst` mid-frame: any beat held in the output register is discarded and not presented after reset. The next frame starts from IDLE.

## Configuration
- `AXIS_ADD_TAIL_CNT_EN` defined:
  - Tail data = `TAIL_MARKER` with bits `[CNT_WIDTH-1:0]` replaced by `cnt`, the data beats actually sent.
  - Upper bits remain `TAIL_MARKER[DATA_WIDTH-1:CNT_WIDTH]`.
- Not defined: tail data = `TAIL_MARKER` verbatim, and the `cnt` path into tdata is removed. `cnt` remains for FSM control.

## Test plan
- Nominal frame, with `frame_len=4`, beats 0x11..0x14 presented, and ready held high:
  - Output is 0x11,0x12,0x13,0x14 with tlast=0.
  - Then the tail, 0xFFFF_0000_0000_0004 with macro or 0xFFFF_0000_0000_0000 without, tlast=1.
  - The first beat of the next frame appears 2 cycles after the tail.
- Early end, with `frame_len=8` and `s_axis_tlast=1` on the 3rd beat: 3 data beats, then a tail whose count field is 0x0003. The 4th input beat is stalled until the next frame's DATA.
- Backpressure: `m_axis_tready` low for 5 cycles while a data beat is held. tdata, tlast and tvalid stay stable, and `s_axis_tready=0`. No beat is lost or duplicated.
- Zero length, `frame_len=0` for 6 cycles: 3 tail-only beats with count 0x0000, and `s_axis_tready` stays 0.
- Reset mid-frame: `rst` asserted after 2 of 4 beats. The next cycle shows `m_axis_tvalid=0` and `s_axis_tready=0`. The following frame emits a full 4 beats plus a tail with count 0x0004.
